mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage
//  (load/store) of the 5-stage riscv pipeline. Sequences multi-cycle accesses with an IDLE/ACCESS FSM.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_pick.sv | 22 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the FSM state encoding, the access owner encoding and the access counter width.
package rv_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_DM = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant selection: data wins over fetch unless fetch has been
// passed over MAX_DM_STREAK times in a row while it was waiting.
module mem_arb_pick
    import rv_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_dm
);

    logic starved;

    assign starved  = (streak == STREAK_W'(MAX_DM_STREAK));
    assign grant_if = if_req & (~dm_req | starved);
    assign grant_dm = dm_req & ~grant_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// IDLE/ACCESS FSM runs fixed-latency accesses with one turnaround cycle between them.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 4,
    parameter int STREAK_W      = $clog2(MAX_DM_STREAK + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                pipe_stall,
    output logic                fsm_state,
    output logic [STREAK_W-1:0] dm_streak
);

    localparam logic [0:0]       S_IDLE   = IDLE;
    localparam logic [0:0]       S_ACCESS = ACCESS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    logic [0:0]          state;
    logic [CNT_W-1:0]    cnt;
    owner_t              owner;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   if_hold;
    logic [DATA_W-1:0]   dm_hold;
    logic [STREAK_W-1:0] streak;

    logic grant_if;
    logic grant_dm;
    logic in_access;
    logic last_cycle;

    mem_arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_pick (
        .if_req   (if_req),
        .dm_req   (dm_req),
        .streak   (streak),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    // Done and memory outputs derive from async-reset state, so reset kills them at once.
    assign in_access  = (state == S_ACCESS);
    assign last_cycle = in_access && (cnt == LAST_CNT);

    assign if_done = last_cycle && (owner == OWN_IF);
    assign dm_done = last_cycle && (owner == OWN_DM);

    assign if_rdata = if_done ? mem_rdata : if_hold;
    assign dm_rdata = (dm_done && !lat_we) ? mem_rdata : dm_hold;

    assign mem_en    = in_access;
    assign mem_we    = in_access & lat_we;
    assign mem_addr  = in_access ? lat_addr : '0;
    assign mem_wdata = in_access ? lat_wdata : '0;

    assign pipe_stall = ~reset & ((if_req & ~if_done) | (dm_req & ~dm_done));

    assign fsm_state = state;
    assign dm_streak = streak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            owner     <= NONE;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            if_hold   <= '0;
            dm_hold   <= '0;
            streak    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm) begin
                        state     <= S_ACCESS;
                        cnt       <= '0;
                        owner     <= OWN_DM;
                        lat_addr  <= dm_addr;
                        lat_we    <= dm_we;
                        lat_wdata <= dm_wdata;
                        // Only wins over a waiting fetch count toward starvation.
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_if) begin
                        state     <= S_ACCESS;
                        cnt       <= '0;
                        owner     <= OWN_IF;
                        lat_addr  <= if_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= '0;
                        streak    <= '0;
                    end
                end
                S_ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        state <= S_IDLE;
                        owner <= NONE;
                        if (owner == OWN_IF) begin
                            if_hold <= mem_rdata;
                        end
                        if ((owner == OWN_DM) && !lat_we) begin
                            dm_hold <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and MAX_DM_STREAK=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pipe_stall;
    logic        fsm_state;
    logic [2:0]  dm_streak;

    int n_pass;
    int n_total;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MEM_LAT       (2),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_done    (dm_done),
        .dm_rdata   (dm_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pipe_stall (pipe_stall),
        .fsm_state  (fsm_state),
        .dm_streak  (dm_streak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = 32'hFFFF_FFFF;
        next_cycle;
        next_cycle;
        @(negedge clk);
        n_total++; if ({mem_en, mem_we, if_done, dm_done} !== 4'b0) $display("FAIL rst_ctrl got=%b exp=0000", {mem_en, mem_we, if_done, dm_done}); else n_pass++;
        n_total++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL rst_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); else n_pass++;
        n_total++; if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL rst_rdata got=%h exp=0", {if_rdata, dm_rdata}); else n_pass++;
        n_total++; if (pipe_stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", pipe_stall); else n_pass++;
        n_total++; if ({fsm_state, dm_streak} !== 4'b0) $display("FAIL rst_state got=%b exp=0000", {fsm_state, dm_streak}); else n_pass++;
        next_cycle;
        reset = 1'b0; if_req = 1'b0;
        @(negedge clk);
        n_total++; if ({fsm_state, mem_en} !== 2'b00) $display("FAIL rst_release_idle got=%b exp=00", {fsm_state, mem_en}); else n_pass++;
    endtask

    task automatic test_if_fetch;
        next_cycle;
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        n_total++; if ({mem_en, pipe_stall} !== 2'b01) $display("FAIL fetch_c0 en_stall got=%b exp=01", {mem_en, pipe_stall}); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({mem_en, mem_we, if_done} !== 3'b100) $display("FAIL fetch_c1 en_we_done got=%b exp=100", {mem_en, mem_we, if_done}); else n_pass++;
        n_total++; if (mem_addr !== 32'h10) $display("FAIL fetch_c1 addr got=%h exp=00000010", mem_addr); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({mem_en, if_done, pipe_stall} !== 3'b110) $display("FAIL fetch_c2 en_done_stall got=%b exp=110", {mem_en, if_done, pipe_stall}); else n_pass++;
        n_total++; if (mem_addr !== 32'h10) $display("FAIL fetch_c2 addr got=%h exp=00000010", mem_addr); else n_pass++;
        n_total++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_c2 rdata got=%h exp=00500093", if_rdata); else n_pass++;
        next_cycle;
        if_req = 1'b0; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        n_total++; if ({mem_en, if_done} !== 2'b00) $display("FAIL fetch_c3 en_done got=%b exp=00", {mem_en, if_done}); else n_pass++;
        n_total++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_c3 held_rdata got=%h exp=00500093", if_rdata); else n_pass++;
    endtask

    task automatic test_contention;
        logic [5:0] stall_seen;
        next_cycle;
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        stall_seen[0] = pipe_stall;
        next_cycle;
        @(negedge clk);
        stall_seen[1] = pipe_stall;
        n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h40}) $display("FAIL cont_c1 dm_access got=%b_%h exp=10_00000040", {mem_en, mem_we}, mem_addr); else n_pass++;
        next_cycle;
        @(negedge clk);
        stall_seen[2] = pipe_stall;
        n_total++; if ({dm_done, if_done} !== 2'b10) $display("FAIL cont_c2 dones got=%b exp=10", {dm_done, if_done}); else n_pass++;
        n_total++; if (dm_rdata !== 32'hCAFE_0001) $display("FAIL cont_c2 dm_rdata got=%h exp=cafe0001", dm_rdata); else n_pass++;
        n_total++; if (dm_streak !== 3'd1) $display("FAIL cont_c2 streak got=%0d exp=1", dm_streak); else n_pass++;
        next_cycle;
        dm_req = 1'b0; mem_rdata = 32'h0000_0513;
        @(negedge clk);
        stall_seen[3] = pipe_stall;
        n_total++; if (mem_en !== 1'b0) $display("FAIL cont_c3 turnaround mem_en got=%b exp=0", mem_en); else n_pass++;
        next_cycle;
        @(negedge clk);
        stall_seen[4] = pipe_stall;
        n_total++; if ({mem_en, mem_addr} !== {1'b1, 32'h20}) $display("FAIL cont_c4 if_access got=%b_%h exp=1_00000020", mem_en, mem_addr); else n_pass++;
        next_cycle;
        @(negedge clk);
        stall_seen[5] = pipe_stall;
        n_total++; if ({if_done, if_rdata} !== {1'b1, 32'h0000_0513}) $display("FAIL cont_c5 if_done got=%b_%h exp=1_00000513", if_done, if_rdata); else n_pass++;
        n_total++; if (stall_seen !== 6'b011111) $display("FAIL cont_stall_c5..c0 got=%b exp=011111", stall_seen); else n_pass++;
        next_cycle;
        if_req = 1'b0;
    endtask

    task automatic test_store;
        next_cycle;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        next_cycle;
        dm_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) $display("FAIL store_c1 bus got=%b_%h_%h exp=11_00000040_deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({mem_we, mem_wdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL store_c2 bus got=%b_%h exp=1_deadbeef", mem_we, mem_wdata); else n_pass++;
        n_total++; if ({dm_done, dm_rdata} !== {1'b1, 32'hCAFE_0001}) $display("FAIL store_c2 done_rdata got=%b_%h exp=1_cafe0001", dm_done, dm_rdata); else n_pass++;
        next_cycle;
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        n_total++; if ({mem_we, dm_done, dm_rdata} !== {2'b00, 32'hCAFE_0001}) $display("FAIL store_c3 after got=%b_%h exp=00_cafe0001", {mem_we, dm_done}, dm_rdata); else n_pass++;
    endtask

    task automatic test_starvation;
        int dm_cnt;
        int dm_before_if;
        int if_cyc;
        int resume_cyc;
        logic [2:0] streak_at_if;
        logic [2:0] streak_at_resume;
        bit if_seen;
        bit resumed;
        dm_cnt = 0; dm_before_if = -1; if_cyc = -1; resume_cyc = -1;
        streak_at_if = 3'd7; streak_at_resume = 3'd7; if_seen = 0; resumed = 0;
        next_cycle;
        if_req = 1'b1; if_addr = 32'h24; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        mem_rdata = 32'h1234_5678;
        for (int cyc = 0; cyc < 40 && !resumed; cyc++) begin
            @(negedge clk);
            if (dm_done) begin
                if (!if_seen) dm_cnt++;
                else begin resumed = 1; resume_cyc = cyc; streak_at_resume = dm_streak; end
            end
            if (if_done && !if_seen) begin
                if_seen = 1; if_cyc = cyc; dm_before_if = dm_cnt; streak_at_if = dm_streak;
            end
            next_cycle;
            if (if_seen) if_req = 1'b0;
            if (resumed) dm_req = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0;
        n_total++; if (dm_before_if !== 4) $display("FAIL starve_dm_before_if got=%0d exp=4", dm_before_if); else n_pass++;
        n_total++; if (if_cyc !== 14) $display("FAIL starve_if_done_cycle got=%0d exp=14", if_cyc); else n_pass++;
        n_total++; if (streak_at_if !== 3'd0) $display("FAIL starve_streak_after_if got=%0d exp=0", streak_at_if); else n_pass++;
        n_total++; if (resume_cyc !== 17) $display("FAIL starve_dm_resume_cycle got=%0d exp=17", resume_cyc); else n_pass++;
        n_total++; if (streak_at_resume !== 3'd0) $display("FAIL starve_streak_uncontended got=%0d exp=0", streak_at_resume); else n_pass++;
    endtask

    task automatic test_reset_mid;
        next_cycle;
        if_req = 1'b1; if_addr = 32'h30; mem_rdata = 32'h0BAD_F00D;
        next_cycle;
        @(negedge clk);
        n_total++; if (mem_en !== 1'b1) $display("FAIL rmid_c1 access_started got=%b exp=1", mem_en); else n_pass++;
        next_cycle;
        reset = 1'b1;
        #1;
        n_total++; if ({mem_en, if_done, pipe_stall} !== 3'b000) $display("FAIL rmid_immediate got=%b exp=000", {mem_en, if_done, pipe_stall}); else n_pass++;
        n_total++; if ({mem_addr, if_rdata} !== 64'h0) $display("FAIL rmid_immediate_data got=%h exp=0", {mem_addr, if_rdata}); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({if_done, mem_en, fsm_state} !== 3'b000) $display("FAIL rmid_held got=%b exp=000", {if_done, mem_en, fsm_state}); else n_pass++;
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if ({mem_en, if_done} !== 2'b00) $display("FAIL rmid_r0 got=%b exp=00", {mem_en, if_done}); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({mem_en, if_done, mem_addr} !== {2'b10, 32'h30}) $display("FAIL rmid_r1 got=%b_%h exp=10_00000030", {mem_en, if_done}, mem_addr); else n_pass++;
        next_cycle;
        @(negedge clk);
        n_total++; if ({if_done, if_rdata} !== {1'b1, 32'h0BAD_F00D}) $display("FAIL rmid_r2 got=%b_%h exp=1_0badf00d", if_done, if_rdata); else n_pass++;
        next_cycle;
        if_req = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        n_total++; if ({mem_en, if_rdata} !== {1'b0, 32'h0BAD_F00D}) $display("FAIL rmid_r3 got=%b_%h exp=0_0badf00d", mem_en, if_rdata); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset;
        test_if_fetch;
        test_contention;
        test_store;
        test_starvation;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
